// File: rtl/instruction_fetch_unit_if.sv
// Instruction-fetch bus bundle: the instruction-memory port, the redirect input and the ID handshake.
// The master modport is the fetch unit; the slave modport is the ROM/decode side.
interface instruction_fetch_unit_if #(
    parameter int DEPTH = 4
);
    logic [31:0]             imem_addr;
    logic [31:0]             imem_instr;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic                    if_valid;
    logic                    if_ready;
    logic [31:0]             if_instr;
    logic [31:0]             if_pc;
    logic [31:0]             if_pc_plus4;
    logic                    if_misalign;
    logic [$clog2(DEPTH):0]  fifo_level;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        output if_misalign,
        output fifo_level
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        input  if_misalign,
        input  fifo_level
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner with a DEPTH-entry prefetch FIFO feeding ID over valid/ready.
// Optional feature macro: IF_ALIGN_CHECK_EN (flag misaligned redirect targets and freeze fetch).
module instruction_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset,
    instruction_fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic          head_valid;
    logic          pop;
    logic          push;
    logic          fetch_en;
    logic          head_misalign;
    logic [31:0]   redirect_target;
    logic [31:0]   head_pc;

`ifdef IF_ALIGN_CHECK_EN
    logic mis_q [DEPTH];
    logic target_misaligned;
    logic frozen;

    assign redirect_target = bus.redirect_pc;
    assign fetch_en        = !frozen;
    assign head_misalign   = mis_q[rd_ptr];

    // A misaligned target is fetched exactly once, then fetch waits for a fresh redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_misaligned <= 1'b0;
            frozen            <= 1'b0;
        end else if (bus.redirect_valid) begin
            target_misaligned <= |bus.redirect_pc[1:0];
            frozen            <= 1'b0;
        end else if (push && target_misaligned) begin
            target_misaligned <= 1'b0;
            frozen            <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mis_q[wr_ptr] <= target_misaligned;
        end
    end
`else
    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
    assign fetch_en        = 1'b1;
    assign head_misalign   = 1'b0;
`endif

    assign head_valid = (level != '0);
    assign pop        = head_valid && bus.if_ready;
    assign push       = !reset && !bus.redirect_valid && fetch_en
                        && ((level != FULL_LEVEL) || pop);

    assign head_pc          = head_valid ? pc_q[rd_ptr] : 32'h0;
    assign bus.imem_addr    = fetch_pc;
    assign bus.if_valid     = head_valid;
    assign bus.if_instr     = head_valid ? instr_q[rd_ptr] : 32'h0;
    assign bus.if_pc        = head_pc;
    assign bus.if_pc_plus4  = head_pc + 32'd4;
    assign bus.if_misalign  = head_valid && head_misalign;
    assign bus.fifo_level   = level;

    // Redirect wins over any handshake on the same edge: the head is dropped, not consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= redirect_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_instr;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instruction_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;

    int total  = 0;
    int passed = 0;

    entry_t      mq[$];
    logic [31:0] mpc;
    logic        mmis;
    logic        mfrozen;
    bit          checking = 1'b0;

    instruction_fetch_unit_if #(.DEPTH(DEPTH)) bus ();

    instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] idx);
        case (idx)
            8'd0:    rom_word = 32'h0800_0003;
            8'd1:    rom_word = 32'h0800_0028;
            default: rom_word = {16'hC0DE, 8'h00, idx};
        endcase
    endfunction

    assign bus.imem_instr     = rom_word(bus.imem_addr[9:2]);
    assign bus.redirect_valid = rv;
    assign bus.redirect_pc    = rpc;
    assign bus.if_ready       = rdy;

    // Reference model: an ordered queue of fetched words advanced by the rules at each edge.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (reset) begin
            mq.delete();
            mpc      = RESET_PC;
            mmis     = 1'b0;
            mfrozen  = 1'b0;
            checking = 1'b1;
        end else if (rv) begin
            mq.delete();
            mpc     = ALIGN_CHECK ? rpc : {rpc[31:2], 2'b00};
            mmis    = ALIGN_CHECK && (rpc[1:0] != 2'b00);
            mfrozen = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            do_push = !mfrozen && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{instr: rom_word(mpc[9:2]), pc: mpc, mis: mmis});
                if (mmis) begin
                    mfrozen = 1'b1;
                    mmis    = 1'b0;
                end
                mpc = mpc + 32'd4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model imem_addr", bus.imem_addr, mpc);
            checkOutput("model if_valid", 32'(bus.if_valid), 32'(mq.size() != 0));
            checkOutput("model fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
            if (mq.size() != 0) begin
                checkOutput("model if_instr", bus.if_instr, mq[0].instr);
                checkOutput("model if_pc", bus.if_pc, mq[0].pc);
                checkOutput("model if_pc_plus4", bus.if_pc_plus4, mq[0].pc + 32'd4);
                checkOutput("model if_misalign", 32'(bus.if_misalign), 32'(mq[0].mis));
            end else begin
                checkOutput("empty if_instr", bus.if_instr, 32'h0);
                checkOutput("empty if_pc", bus.if_pc, 32'h0);
                checkOutput("empty if_pc_plus4", bus.if_pc_plus4, 32'h4);
                checkOutput("empty if_misalign", 32'(bus.if_misalign), 32'h0);
            end
        end
    end

    // Drive inputs for the coming edge, then return shortly after that edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] p,
                                 input logic ready);
        reset = r;
        rv    = v;
        rpc   = p;
        rdy   = ready;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        rv    = 1'b0;
        rpc   = 32'h0;
        rdy   = 1'b1;
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("reset if_valid", 32'(bus.if_valid), 32'h0);
        checkOutput("reset if_pc_plus4", bus.if_pc_plus4, 32'h4);

        $display("[TB] streaming after reset");
        applyStimulus(0, 0, 0, 1);
        checkOutput("stream pc0", bus.if_pc, 32'h0);
        checkOutput("stream instr0", bus.if_instr, 32'h0800_0003);
        applyStimulus(0, 0, 0, 1);
        checkOutput("stream pc4", bus.if_pc, 32'h4);
        checkOutput("stream instr4", bus.if_instr, 32'h0800_0028);
        checkOutput("stream level", 32'(bus.fifo_level), 32'h1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("stream pc8", bus.if_pc, 32'h8);

        $display("[TB] back-pressure to full");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("full level", 32'(bus.fifo_level), 32'h4);
        checkOutput("full imem_addr", bus.imem_addr, 32'h10);
        checkOutput("full head pc", bus.if_pc, 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain pc4", bus.if_pc, 32'h4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain pc8", bus.if_pc, 32'h8);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain pcC", bus.if_pc, 32'hC);
        checkOutput("drain level", 32'(bus.fifo_level), 32'h4);

        $display("[TB] redirect on full FIFO");
        applyStimulus(0, 1, 32'h4, 1);
        checkOutput("redirect level", 32'(bus.fifo_level), 32'h0);
        checkOutput("redirect valid", 32'(bus.if_valid), 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("redirect pc", bus.if_pc, 32'h4);
        checkOutput("redirect instr", bus.if_instr, 32'h0800_0028);

        $display("[TB] pc wrap");
        applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap pc", bus.if_pc, 32'hFFFF_FFFC);
        checkOutput("wrap pc_plus4", bus.if_pc_plus4, 32'h0);
        checkOutput("wrap instr", bus.if_instr, 32'hC0DE_00FF);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap next pc", bus.if_pc, 32'h0);

        $display("[TB] reset mid-stream");
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre-reset level", 32'(bus.fifo_level), 32'h3);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mid reset valid", 32'(bus.if_valid), 32'h0);
        checkOutput("mid reset level", 32'(bus.fifo_level), 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("post reset pc", bus.if_pc, 32'h0);

        $display("[TB] back-to-back redirects");
        applyStimulus(0, 1, 32'h100, 1);
        applyStimulus(0, 1, 32'h8, 1);
        checkOutput("b2b level", 32'(bus.fifo_level), 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("b2b pc", bus.if_pc, 32'h8);

        $display("[TB] misaligned redirect");
        applyStimulus(0, 1, 32'h22, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("misalign instr", bus.if_instr, 32'hC0DE_0008);
`ifdef IF_ALIGN_CHECK_EN
        checkOutput("misalign pc", bus.if_pc, 32'h22);
        checkOutput("misalign flag", 32'(bus.if_misalign), 32'h1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("frozen level", 32'(bus.fifo_level), 32'h0);
`else
        checkOutput("misalign pc", bus.if_pc, 32'h20);
        checkOutput("misalign flag", 32'(bus.if_misalign), 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("stream after misalign", bus.if_pc, 32'h24);
`endif
        applyStimulus(0, 1, 32'h40, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("resume pc", bus.if_pc, 32'h40);

        $display("[TB] random ready/redirect traffic");
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0)
                applyStimulus(0, 1, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 1'($urandom_range(0, 1)));
            else
                applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
